// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the two ports sharing the data memory.
// The arbiter takes the slave view; requesters (or a bench) take the master view.
interface dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_lock;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m0_ack, m0_rdata, m1_ack, m1_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 16-bit data memory (IDLE -> ACCESS -> DONE).
// Optional lock starvation guard: define DMEM_ARB_LOCK_TIMEOUT_EN.
module dmem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] ALUresult,
    output logic [DW-1:0] WriteData,
    input  logic [DW-1:0] data_result,
    output logic          busy,
    output logic          owner
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

    state_t        state, state_nxt;
    logic          grant;
    logic          win;
    logic          timeout;
    logic          last_served;
    logic          last_lock;

    logic          cmd_we;
    logic          cmd_lock;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] rdata_q;

`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
    logic [3:0] lock_cnt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction
`else
    logic unused_max_lock;
    assign unused_max_lock = ^MAX_LOCK_C;
`endif

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win       = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                    if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
                        timeout = last_lock && (lock_cnt >= MAX_LOCK_C);
`endif
                        // A held lock keeps the last owner; otherwise rotate.
                        win = (last_lock && !timeout) ? last_served : ~last_served;
                    end else begin
                        win = bus.m1_req;
                    end
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            last_lock   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant)
                owner <= win;
            if (state == DONE) begin
                last_served <= owner;
                last_lock   <= cmd_lock;
            end
        end
    end

    // Command and read-data registers carry no reset; every consumer is gated by state.
    always_ff @(posedge clk) begin
        if (grant) begin
            cmd_we    <= win ? bus.m1_we    : bus.m0_we;
            cmd_lock  <= win ? bus.m1_lock  : bus.m0_lock;
            cmd_addr  <= win ? bus.m1_addr  : bus.m0_addr;
            cmd_wdata <= win ? bus.m1_wdata : bus.m0_wdata;
        end
        if (state == ACCESS)
            rdata_q <= cmd_we ? '0 : data_result;
    end

`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lock_cnt <= 4'd0;
        else if (grant && timeout)
            lock_cnt <= 4'd0;
        else if (state == DONE)
            lock_cnt <= (owner == last_served && cmd_lock) ? sat_inc(lock_cnt) : 4'd0;
    end
`endif

    assign busy      = (state != IDLE);
    assign MemRead   = (state == ACCESS) && !cmd_we;
    assign MemWrite  = (state == ACCESS) && cmd_we;
    assign ALUresult = (state == ACCESS) ? cmd_addr  : '0;
    assign WriteData = (state == ACCESS) ? cmd_wdata : '0;

    assign bus.m0_ack   = (state == DONE) && !owner;
    assign bus.m1_ack   = (state == DONE) && owner;
    assign bus.m0_rdata = bus.m0_ack ? rdata_q : '0;
    assign bus.m1_rdata = bus.m1_ack ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: queued requesters, a memory array, and a transaction-timeline
// reference model that predicts every output each cycle.
module tb_dmem_arbiter;
    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int MAX_LOCK = 8;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        lock;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          MemRead, MemWrite, busy, owner;
    logic [AW-1:0] ALUresult;
    logic [DW-1:0] WriteData, data_result;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUresult(ALUresult),
        .WriteData(WriteData), .data_result(data_result), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:255];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (MemWrite) begin
            mem[ALUresult[7:0]] <= WriteData;
        end
    end
    assign data_result = mem[ALUresult[7:0]];
    logic unused_hi;
    assign unused_hi = ^ALUresult[15:8];

    logic [69:0] obs_v;
    assign obs_v = {busy, owner, MemRead, MemWrite, ALUresult, WriteData,
                    bus.m0_ack, bus.m0_rdata, bus.m1_ack, bus.m1_rdata};

    int passed = 0;
    int total  = 0;

    cmd_t q0[$];
    cmd_t q1[$];
    logic en0 = 1'b1, drop0 = 1'b0;

    // Reference model state
    int          ecyc = 0;
    int          free_at = 0;
    int          g_cyc = -10;
    logic        g_port;
    cmd_t        g_cmd;
    logic [15:0] g_rdata;
    logic        last_served, last_lock, m_owner;
    int          run;
    logic [15:0] ref_mem [0:255];
    logic [69:0] exp_v;

    function automatic cmd_t mk(input logic we, input logic [15:0] a,
                                input logic [15:0] d, input logic l);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d; c.lock = l;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd(input int lock_pct);
        return mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)),
                  16'($urandom), $urandom_range(0, 99) < lock_pct);
    endfunction

    task automatic drive_inputs();
        cmd_t c0, c1;
        c0 = (q0.size() > 0) ? q0[0] : '0;
        c1 = (q1.size() > 0) ? q1[0] : '0;
        bus.m0_req = en0 && !drop0 && (q0.size() > 0);
        bus.m0_we = c0.we; bus.m0_addr = c0.addr; bus.m0_wdata = c0.wdata; bus.m0_lock = c0.lock;
        bus.m1_req = (q1.size() > 0);
        bus.m1_we = c1.we; bus.m1_addr = c1.addr; bus.m1_wdata = c1.wdata; bus.m1_lock = c1.lock;
    endtask

    task automatic model_reset();
        last_served = 1'b1; last_lock = 1'b0; m_owner = 1'b0; run = 0;
        g_cyc = -10; free_at = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        q0.delete(); q1.delete();
        en0 = 1'b1; drop0 = 1'b0;
        drive_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock: arbitrate from the spec rules at the edge, predict outputs, advance requesters.
    task automatic step();
        logic r0, r1, w, keep;
        cmd_t c;
        @(posedge clk);
        ecyc++;
        r0 = bus.m0_req; r1 = bus.m1_req;
        if (ecyc >= free_at && (r0 || r1)) begin
            if (r0 && r1) begin
                keep = last_lock;
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
                if (keep && run >= MAX_LOCK) begin
                    keep = 1'b0;
                    run  = 0;
                end
`endif
                w = keep ? last_served : !last_served;
            end else begin
                w = r1;
            end
            c = w ? q1[0] : q0[0];
            g_rdata = c.we ? 16'h0 : ref_mem[c.addr[7:0]];
            if (c.we) ref_mem[c.addr[7:0]] = c.wdata;
            run = (w == last_served && c.lock) ? ((run < 15) ? run + 1 : 15) : 0;
            last_served = w; last_lock = c.lock; m_owner = w;
            g_cyc = ecyc; g_port = w; g_cmd = c; free_at = ecyc + 3;
        end
        @(negedge clk);
        if (ecyc == g_cyc)
            exp_v = {1'b1, m_owner, !g_cmd.we, g_cmd.we, g_cmd.addr, g_cmd.wdata, 34'h0};
        else if (ecyc == g_cyc + 1)
            exp_v = {1'b1, m_owner, 2'b00, 32'h0,
                     !g_port, (!g_port) ? g_rdata : 16'h0, g_port, g_port ? g_rdata : 16'h0};
        else
            exp_v = {1'b0, m_owner, 68'h0};
        if (ecyc == g_cyc + 2) begin
            if (g_port) void'(q1.pop_front());
            else        void'(q0.pop_front());
        end
        drive_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_inputs();
        model_reset();
        #1;
        total++;
        if (obs_v !== 70'h0) $display("FAIL reset_outputs got=%h want=0", obs_v);
        else passed++;
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        @(negedge clk);
        total++;
        if (obs_v !== 70'h0) $display("FAIL reset_held_with_req got=%h want=0", obs_v);
        else passed++;
        drive_inputs();
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        int n_wr = 0, cyc = 0;
        logic [15:0] rd = 16'h0;
        apply_reset();
        q0.push_back(mk(1'b1, 16'h0010, 16'hBEEF, 1'b0));
        q0.push_back(mk(1'b0, 16'h0010, 16'h0000, 1'b0));
        drive_inputs();
        while (q0.size() > 0 && cyc < 40) begin
            step(); cyc++;
            total++;
            if (obs_v !== exp_v) $display("FAIL wr_rd_cycle got=%h want=%h", obs_v, exp_v);
            else passed++;
            if (MemWrite) n_wr++;
            if (bus.m0_ack && !g_cmd.we) rd = bus.m0_rdata;
        end
        total++;
        if (q0.size() != 0) $display("FAIL wr_rd_timeout pending=%0d want=0", q0.size());
        else passed++;
        total++;
        if (n_wr != 1) $display("FAIL wr_strobe_cycles got=%0d want=1", n_wr);
        else passed++;
        total++;
        if (rd !== 16'hBEEF) $display("FAIL rd_data got=%h want=beef", rd);
        else passed++;
    endtask

    task automatic test_tie();
        int cyc = 0, t0 = -1, t1 = -1;
        apply_reset();
        q0.push_back(mk(1'b0, 16'h0002, 16'h0, 1'b0));
        q1.push_back(mk(1'b0, 16'h0004, 16'h0, 1'b0));
        drive_inputs();
        while ((q0.size() + q1.size()) > 0 && cyc < 40) begin
            step(); cyc++;
            total++;
            if (obs_v !== exp_v) $display("FAIL tie_cycle got=%h want=%h", obs_v, exp_v);
            else passed++;
            if (bus.m0_ack && t0 < 0) t0 = ecyc;
            if (bus.m1_ack && t1 < 0) t1 = ecyc;
        end
        total++;
        if (t0 < 0 || t1 != t0 + 3) $display("FAIL tie_order t0=%0d t1=%0d want t1=t0+3", t0, t1);
        else passed++;
    endtask

    task automatic test_round_robin();
        int cyc = 0;
        int seq[$];
        int tim[$];
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rnd_cmd(0));
            q1.push_back(rnd_cmd(0));
        end
        drive_inputs();
        while ((q0.size() + q1.size()) > 0 && cyc < 60) begin
            step(); cyc++;
            total++;
            if (obs_v !== exp_v) $display("FAIL rr_cycle got=%h want=%h", obs_v, exp_v);
            else passed++;
            if (bus.m0_ack) begin seq.push_back(0); tim.push_back(ecyc); end
            if (bus.m1_ack) begin seq.push_back(1); tim.push_back(ecyc); end
        end
        total++;
        if (seq.size() != 8) $display("FAIL rr_ack_count got=%0d want=8", seq.size());
        else passed++;
        for (int i = 0; i < seq.size(); i++) begin
            total++;
            if (seq[i] != (i % 2) || (i > 0 && tim[i] != tim[i-1] + 3))
                $display("FAIL rr_order idx=%0d port=%0d want=%0d", i, seq[i], i % 2);
            else passed++;
        end
    endtask

    task automatic test_lock();
        int cyc = 0, m1_before = 0, want;
        logic seen0 = 1'b0;
        apply_reset();
        en0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            q1.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom), 1'b1));
            q0.push_back(rnd_cmd(0));
        end
        drive_inputs();
        while ((q0.size() + q1.size()) > 0 && cyc < 150) begin
            step(); cyc++;
            total++;
            if (obs_v !== exp_v) $display("FAIL lock_cycle got=%h want=%h", obs_v, exp_v);
            else passed++;
            if (bus.m1_ack && !seen0) m1_before++;
            if (bus.m0_ack) seen0 = 1'b1;
            if (bus.m1_ack && !en0) begin en0 = 1'b1; drive_inputs(); end
        end
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
        want = MAX_LOCK;
`else
        want = 12;
`endif
        total++;
        if (m1_before != want) $display("FAIL lock_run got=%0d want=%0d", m1_before, want);
        else passed++;
        total++;
        if ((q0.size() + q1.size()) != 0) $display("FAIL lock_timeout pending=%0d want=0", q0.size() + q1.size());
        else passed++;
    endtask

    task automatic test_drop();
        int cyc = 0, wr_acks = 0;
        logic [15:0] rd = 16'h0;
        apply_reset();
        q0.push_back(mk(1'b1, 16'h0020, 16'h1234, 1'b0));
        q0.push_back(mk(1'b0, 16'h0020, 16'h0000, 1'b0));
        drive_inputs();
        while (q0.size() > 0 && cyc < 40) begin
            step(); cyc++;
            total++;
            if (obs_v !== exp_v) $display("FAIL drop_cycle got=%h want=%h", obs_v, exp_v);
            else passed++;
            if (bus.m0_ack && g_cmd.we) wr_acks++;
            if (bus.m0_ack && !g_cmd.we) rd = bus.m0_rdata;
            if (ecyc == g_cyc && g_cmd.we) drop0 = 1'b1;
            if (ecyc == g_cyc + 2) drop0 = 1'b0;
            drive_inputs();
        end
        total++;
        if (wr_acks != 1) $display("FAIL drop_ack_count got=%0d want=1", wr_acks);
        else passed++;
        total++;
        if (rd !== 16'h1234) $display("FAIL drop_readback got=%h want=1234", rd);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        int cyc = 0, first = -1;
        apply_reset();
        q0.push_back(mk(1'b1, 16'h0030, 16'h5A5A, 1'b0));
        drive_inputs();
        while (!(ecyc == g_cyc && cyc > 0) && cyc < 10) begin
            step(); cyc++;
        end
        total++;
        if (MemWrite !== 1'b1 || busy !== 1'b1) $display("FAIL midrst_pre memwrite=%b busy=%b want=1,1", MemWrite, busy);
        else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if (obs_v !== 70'h0) $display("FAIL midrst_async got=%h want=0", obs_v);
        else passed++;
        apply_reset();
        q0.push_back(mk(1'b0, 16'h0030, 16'h0, 1'b0));
        q1.push_back(mk(1'b0, 16'h0031, 16'h0, 1'b0));
        drive_inputs();
        cyc = 0;
        while ((q0.size() + q1.size()) > 0 && cyc < 40) begin
            step(); cyc++;
            total++;
            if (obs_v !== exp_v) $display("FAIL midrst_cycle got=%h want=%h", obs_v, exp_v);
            else passed++;
            if (first < 0 && bus.m0_ack) first = 0;
            if (first < 0 && bus.m1_ack) first = 1;
        end
        total++;
        if (first != 0) $display("FAIL midrst_tie first=%0d want=0", first);
        else passed++;
    endtask

    task automatic test_random();
        int cyc = 0;
        for (int i = 0; i < 15; i++) begin
            q0.push_back(rnd_cmd(25));
            q1.push_back(rnd_cmd(25));
        end
        drive_inputs();
        while ((q0.size() + q1.size()) > 0 && cyc < 200) begin
            step(); cyc++;
            total++;
            if (obs_v !== exp_v) $display("FAIL random_cycle got=%h want=%h", obs_v, exp_v);
            else passed++;
        end
        total++;
        if ((q0.size() + q1.size()) != 0) $display("FAIL random_timeout pending=%0d want=0", q0.size() + q1.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_round_robin();
        test_lock();
        test_drop();
        test_random();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
